// File: rtl/pixel_assembler.sv
`default_nettype none
// ============================================================================
// Module  : pixel_assembler
// Brief   : Packs a byte-serial R,G,B subpixel stream into {R,G,B} pixels
//           with a one-entry output register and SOF resynchronisation.
// Revision: 1.0
// ============================================================================
module pixel_assembler #(
    parameter int P_PIXEL_DEPTH    = 24,
    parameter int P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3,
    parameter int P_COUNT_WIDTH    = 16
) (
    input  logic                        I_CLK,
    input  logic                        I_RESET,
    input  logic [P_SUBPIXEL_DEPTH-1:0] I_SUBPIXEL,
    input  logic                        I_SUBPIXEL_VALID,
    input  logic                        I_SOF,
    output logic                        O_SUBPIXEL_READY,
    output logic [P_PIXEL_DEPTH-1:0]    O_PIXEL,
    output logic                        O_PIXEL_VALID,
    input  logic                        I_PIXEL_READY,
    output logic [P_COUNT_WIDTH-1:0]    O_PIXEL_COUNT,
    output logic                        O_SYNC_ERR
);

    localparam logic [P_COUNT_WIDTH-1:0] C_COUNT_ONE = P_COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_R = 2'd0,
        S_G = 2'd1,
        S_B = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [P_SUBPIXEL_DEPTH-1:0] r_q, r_d;
    logic [P_SUBPIXEL_DEPTH-1:0] g_q, g_d;
    logic [P_PIXEL_DEPTH-1:0]    pixel_q, pixel_d;
    logic                        pixel_valid_q, pixel_valid_d;
    logic [P_COUNT_WIDTH-1:0]    count_q, count_d;
    logic                        sync_err_q, sync_err_d;

    logic                        w_ready;
    logic                        w_accept;
    logic                        w_handoff;

    // B may only enter when the output slot is free or draining this cycle.
    always_comb begin
        w_ready = 1'b0;
        if (I_RESET) begin
            w_ready = (state_q == S_B) ? (!pixel_valid_q || I_PIXEL_READY) : 1'b1;
        end
    end

    assign w_accept  = I_SUBPIXEL_VALID && w_ready;
    assign w_handoff = pixel_valid_q && I_PIXEL_READY;

    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        g_d           = g_q;
        pixel_d       = pixel_q;
        pixel_valid_d = pixel_valid_q;
        count_d       = count_q;
        sync_err_d    = 1'b0;

        if (w_handoff) begin
            pixel_valid_d = 1'b0;
            count_d       = count_q + C_COUNT_ONE;
        end

        if (w_accept) begin
            if (I_SOF) begin
                // A pixel handed off on the SOF edge is counted after the clear.
                r_d        = I_SUBPIXEL;
                state_d    = S_G;
                sync_err_d = (state_q != S_R);
                count_d    = w_handoff ? C_COUNT_ONE : '0;
            end else begin
                case (state_q)
                    S_R: begin
                        r_d     = I_SUBPIXEL;
                        state_d = S_G;
                    end
                    S_G: begin
                        g_d     = I_SUBPIXEL;
                        state_d = S_B;
                    end
                    S_B: begin
                        pixel_d       = {r_q, g_q, I_SUBPIXEL};
                        pixel_valid_d = 1'b1;
                        state_d       = S_R;
                    end
                    default: state_d = S_R;
                endcase
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RESET) begin
            state_q       <= S_R;
            r_q           <= '0;
            g_q           <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            count_q       <= '0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            g_q           <= g_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            count_q       <= count_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign O_SUBPIXEL_READY = w_ready;
    assign O_PIXEL          = pixel_q;
    assign O_PIXEL_VALID    = pixel_valid_q;
    assign O_PIXEL_COUNT    = count_q;
    assign O_SYNC_ERR       = sync_err_q;

endmodule
`default_nettype wire

// File: doc/pixel_assembler.md
Name: pixel_assembler

Overview:
- Packs a byte-serial subpixel stream (R, then G, then B) into full 24-bit RGB pixels for the grayscale stage.
- Sits upstream of grayscale: it writes the RGB words that grayscale reads.
- Uses valid/ready handshakes on both sides and has a one-entry output register.
- Resynchronises on a start-of-frame marker and flags frames whose pixels were split by that marker.

Parameters:
- P_PIXEL_DEPTH, 24, output pixel width; must be divisible by 3.
- P_SUBPIXEL_DEPTH, P_PIXEL_DEPTH/3, width of one input subpixel.
- P_COUNT_WIDTH, 16, width of the per-frame pixel counter.

Ports:
- I_CLK  in  1  clock; all logic on rising edge.
- I_RESET  in  1  synchronous, active-low reset.
- I_SUBPIXEL  in  P_SUBPIXEL_DEPTH  incoming subpixel byte.
- I_SUBPIXEL_VALID  in  1  I_SUBPIXEL and I_SOF are valid.
- I_SOF  in  1  qualifies the current byte as the first R of a frame.
- O_SUBPIXEL_READY  out  1  block accepts the byte this cycle.
- O_PIXEL  out  P_PIXEL_DEPTH  assembled pixel, {R,G,B} with R in the MSBs.
- O_PIXEL_VALID  out  1  O_PIXEL holds a pixel.
- I_PIXEL_READY  in  1  downstream accepts O_PIXEL.
- O_PIXEL_COUNT  out  P_COUNT_WIDTH  pixels handed off since the last accepted SOF.
- O_SYNC_ERR  out  1  one-cycle pulse: SOF arrived while a pixel was partially assembled.

Behaviour:
- Reset (I_RESET==0 at a clock edge):
  - State goes to S_R.
  - O_PIXEL_VALID=0, O_PIXEL=0, O_PIXEL_COUNT=0, O_SYNC_ERR=0.
  - R/G holding registers are cleared.
  - O_SUBPIXEL_READY=0 during reset.
  - Reset mid-pixel or with a pending output discards everything; no pixel is emitted afterwards.
- Handshakes:
  - Input accept = I_SUBPIXEL_VALID && O_SUBPIXEL_READY.
  - Output handoff = O_PIXEL_VALID && I_PIXEL_READY.
- FSM states: S_R, S_G, S_B.
  - S_R: ready=1. On accept, store R and go to S_G.
  - S_G: ready=1. On accept, store G and go to S_B.
  - S_B: ready = !O_PIXEL_VALID || I_PIXEL_READY. On accept, O_PIXEL <= {R,G,I_SUBPIXEL}, O_PIXEL_VALID <= 1, go to S_R.
- Latency: B accepted at edge n gives O_PIXEL_VALID=1 in cycle n+1.
- Throughput: one pixel per 3 accepted bytes; a back-to-back stream with I_PIXEL_READY held high never stalls.
- Output register:
  - Handoff without a new B accept clears O_PIXEL_VALID.
  - Handoff and B accept in the same cycle leave O_PIXEL_VALID=1 with the new pixel loaded.
  - O_PIXEL is stable while O_PIXEL_VALID && !I_PIXEL_READY.
- SOF handling:
  - An accepted byte with I_SOF=1 is always treated as R; the block stores it and goes to S_G.
  - If state was S_G or S_B, the partial pixel is dropped and O_SYNC_ERR pulses for exactly one cycle, the cycle after the accept.
  - SOF in S_B while the output is stalled: ready=0, so the byte is not accepted until the output clears.
  - I_SOF is ignored when the byte is not accepted.
- Counter:
  - O_PIXEL_COUNT increments by 1 on each output handoff and wraps modulo 2^P_COUNT_WIDTH.
  - An accepted SOF clears it to 0.
  - SOF accept and handoff in the same cycle give a count of 1: the handed-off pixel is counted after the clear.
- Widths: no arithmetic on pixel data; bit placement only. R occupies O_PIXEL[P_PIXEL_DEPTH-1 -: P_SUBPIXEL_DEPTH].

Test Plan:
- Reset with I_RESET=0 for 2 cycles while driving valid bytes -> O_PIXEL_VALID=0, O_PIXEL_COUNT=0, O_SUBPIXEL_READY=0, no pixel after release.
- SOF+8'hFF, 8'h7F, 8'h00 back-to-back, I_PIXEL_READY=1 -> O_PIXEL=24'hFF7F00 valid exactly 1 cycle after the B accept; O_PIXEL_COUNT=1.
- 4 pixels streamed continuously (12 bytes, ready=1) -> 4 pixels in order, no ready deassertion, O_PIXEL_COUNT=4.
- I_PIXEL_READY=0 with pixel 24'h102030 pending and the next pixel's R,G sent -> R,G accepted; B stalls (O_SUBPIXEL_READY=0); O_PIXEL holds 24'h102030; releasing ready emits 24'h102030, then the next pixel a cycle after its B accept.
- SOF+8'hAA, 8'hBB, then SOF+8'h11, 8'h22, 8'h33 -> O_SYNC_ERR pulses once; only 24'h112233 emitted; O_PIXEL_COUNT=1.
- Count wrap with P_COUNT_WIDTH=2: 5 pixels after SOF -> counts 1,2,3,0,1.
